// File: rtl/serial_input.sv
// serial_input: 8N1 UART receiver with a byte FIFO presented on a 32-bit stb/ack stream.
// rx is synchronized, sampled mid-bit by a down-counter FSM, and good bytes are queued.
module serial_input #(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] out,
    output logic        out_stb,
    input  logic        out_ack,
    output logic        overrun,
    output logic        framing_error
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    logic [1:0]    sync_q;
    logic          rxs;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push;
    logic          ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign rxs = sync_q[1];

    // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
        end
    end

    // Receive FSM next-state: mid-bit sampling, data shift-in, stop-bit check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        cnt_d   = CNT_FULL;
                        bitn_d  = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                    cnt_d   = CNT_FULL;
                    bitn_d  = bitn_q + 1'b1;
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_stb = (count_q != '0);
    assign pop     = out_stb && out_ack;
    assign full    = (count_q == FIFO_FULL);
    assign push_ok = push && (!full || pop);

    // Head is gated by out_stb so out reads zero whenever the FIFO is empty.
    assign out = out_stb ? {24'b0, mem[rd_ptr_q]} : '0;

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shreg_q;
        end
    end

    // FIFO pointers, occupancy and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overrun       <= push && full && !pop;
            framing_error <= ferr;
        end
    end

endmodule

// File: doc/serial_input.md
# serial_input

Receive-side UART front end for the soft-processor stream fabric. Samples an asynchronous serial line (8N1, LSB first), buffers received bytes in a FIFO and presents each byte as a 32-bit word on a stb/ack stream. It drives the `input_rs232_rx` / `input_rs232_rx_stb` / `input_rs232_rx_ack` port group of the generated user design. It is the receiving counterpart of the serial transmitter on `output_rs232_tx`.

## Interface

Parameters:
- `CLOCK_FREQUENCY`, default 100000000: clk frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. `CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE`, truncated; must be ≥ 4.
- `FIFO_DEPTH`, default 16: byte FIFO depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `rx`  in  1  serial line, asynchronous to clk, idle high.
- `out`  out  32  `{24'b0, byte}` at FIFO head.
- `out_stb`  out  1  high while the FIFO is non-empty.
- `out_ack`  in  1  consumer accept.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `framing_error`  out  1  one-cycle pulse when the stop bit samples low.

## Operation

- **Synchronizer.** `rx` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized value `rxs`.
- **Receive FSM.** States IDLE, START, DATA, STOP, RECOVER. A down-counter `cnt` counts clk cycles, and `bitn` (0–7) indexes data bits.
- **IDLE.** When `rxs==0`: load `cnt = CLKS_PER_BIT/2 - 1`, go to START.
- **START.** Decrement `cnt`; at `cnt==0` sample `rxs`.
  - If 0: load `cnt = CLKS_PER_BIT-1`, set `bitn = 0`, go to DATA.
  - If 1: glitch; return to IDLE with no output.
- **DATA.** At `cnt==0`: shift `rxs` into `shreg` MSB (shift right, so LSB is first on the wire), reload `cnt`, increment `bitn`. After `bitn==7` is sampled, go to STOP.
- **STOP.** At `cnt==0` sample `rxs`.
  - If 1: push `shreg` into the FIFO; if the FIFO is full and not popping this cycle, drop the byte and pulse `overrun`. Go to IDLE.
  - If 0: pulse `framing_error`, discard the byte, go to RECOVER.
- **RECOVER.** Stay until `rxs==1`, then go to IDLE. A held-low line (break) therefore produces exactly one `framing_error`.
- **FIFO.** Circular buffer with read/write pointers and an occupancy count `log2(FIFO_DEPTH)+1` bits wide. Pointers wrap modulo `FIFO_DEPTH`.
  - A pop occurs when `out_stb && out_ack`.
  - Full/empty are evaluated on the pre-cycle occupancy.
  - A push while full is accepted when a pop happens in the same cycle; occupancy is unchanged.
  - A simultaneous push and pop when empty cannot occur, because `out_stb` is 0.
  - `out_ack` while `out_stb==0` is ignored.
- **Output.** `out` is driven by the FIFO head. Its upper 24 bits are always 0. `out` holds stable while `out_stb` is high and not acked.

## Timing

- Reset values: `out_stb=0`, `out=0`, `overrun=0`, `framing_error=0`, FSM=IDLE, FIFO empty, synchronizer=1.
- Reset asserted mid-frame aborts the frame; the partial byte is lost. After reset release the FSM waits in IDLE for the next low.
- Sampling points after IDLE detects low:
  - start bit at `CLKS_PER_BIT/2` cycles;
  - data bit k at `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT`;
  - stop bit at `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`.
- Push latency: `out_stb` rises, with `out` valid, on the cycle after the stop-bit sample.
- `overrun` and `framing_error` are asserted for exactly the cycle after the stop-bit sample.
- Throughput: back-to-back frames accepted. IDLE re-arms on the cycle after the stop sample, leaving half a bit of margin before the next start edge.
- Stream: after an ack, the next FIFO entry appears on `out` the following cycle, so one word can transfer per cycle while the FIFO is non-empty.

## Test plan

Bench parameters: `CLOCK_FREQUENCY=16`, `BAUD_RATE=1` (`CLKS_PER_BIT=16`), `FIFO_DEPTH=16`.
- Reset: hold `rst` low 5 cycles with `rx` toggling → all outputs 0. Release `rst` mid-frame, then send 0x42 → only 0x00000042 emerges.
- Single byte: send 0x55 with `out_ack` held high → `out_stb` high for 1 cycle with `out=0x00000055`, one cycle after the stop sample.
- Buffering: `out_ack` low, send 0xA5 then 0x3C back-to-back → `out_stb` stays high, `out=0x000000A5`. Ack for 1 cycle → `out=0x0000003C`. Ack again → `out_stb=0`.
- Glitch: drive `rx` low for 4 cycles, then high → no `out_stb`, no error, FSM returns to IDLE.
- Framing/break: send 0x81 with stop bit 0, hold `rx` low 40 cycles, release, then send 0x12 → exactly one `framing_error` pulse, 0x81 discarded, then `out=0x00000012`.
- Overrun/wrap: `out_ack` low, send 17 bytes 0x00..0x10 → one `overrun` pulse on byte 17. Draining yields 0x00..0x0F in order. Send and drain 20 more bytes → correct order across pointer wrap.
